// File: rtl/avalon_mm_arbiter_pkg.sv
// avalon_mm_pkg: shared widths, watchdog default and arbiter FSM encoding
package avalon_mm_pkg;
   localparam int DW_DEF = 32;
   localparam int AW_DEF = 32;
   localparam int N_DEF = DW_DEF / 8;
   localparam int TIMEOUT_DEF = 64;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
   // pointer width that stays legal for a single master
   function automatic int ptr_w(input int nm);
      return nm > 1 ? $clog2(nm) : 1;
   endfunction
endpackage

// File: rtl/avalon_mm_arbiter_if.sv
// avalon_mm_arbiter_if: master-side request bundle plus the shared slave port
interface avalon_mm_arbiter_if import avalon_mm_pkg::*; #(
   parameter int NM = 2,
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF,
   parameter int N = DW / 8
);
   logic [NM*AW-1:0] m_address;
   logic [NM-1:0] m_read;
   logic [NM-1:0] m_write;
   logic [NM*DW-1:0] m_writedata;
   logic [NM*N-1:0] m_byteenable;
   logic [NM-1:0] m_waitrequest;
   logic [DW-1:0] m_readdata;
   logic [AW-1:0] s_address;
   logic s_read;
   logic s_write;
   logic s_chipselect;
   logic [DW-1:0] s_writedata;
   logic [N-1:0] s_byteenable;
   logic s_waitrequest;
   logic [DW-1:0] s_readdata;
   // master: the arbiter, which masters the shared slave; slave: its environment
   modport master (
      input m_address, m_read, m_write, m_writedata, m_byteenable, s_waitrequest, s_readdata,
      output m_waitrequest, m_readdata, s_address, s_read, s_write, s_chipselect, s_writedata, s_byteenable
   );
   modport slave (
      output m_address, m_read, m_write, m_writedata, m_byteenable, s_waitrequest, s_readdata,
      input m_waitrequest, m_readdata, s_address, s_read, s_write, s_chipselect, s_writedata, s_byteenable
   );
endinterface

// File: rtl/avalon_mm_arbiter_pick.sv
// rr_priority_pick: first requester at or above ptr, wrapping modulo NM
module rr_priority_pick #(
   parameter int NM = 2,
   parameter int PW = 1
) (
   input  logic [NM-1:0] req,
   input  logic [PW-1:0] ptr,
   output logic [NM-1:0] grant,
   output logic [PW-1:0] idx,
   output logic any
);
   logic [PW-1:0] j;
   // scan farthest-first so the nearest requester overwrites
   always_comb begin
      grant = '0;
      idx = '0;
      j = '0;
      for (int k = NM - 1; k >= 0; k--) begin
         j = PW'((int'(ptr) + k) % NM);
         if (req[j]) begin
            idx = j;
            grant = '0;
            grant[j] = 1'b1;
         end
      end
      any = |req;
   end
endmodule

// File: rtl/avalon_mm_arbiter.sv
// avalon_mm_arbiter: round-robin sharing of one Avalon-MM slave with a stall watchdog
module avalon_mm_arbiter import avalon_mm_pkg::*; #(
   parameter int NM = 2,
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF,
   parameter int N = DW / 8,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   avalon_mm_arbiter_if.master bus,
   output logic [NM-1:0] grant,
   output logic timeout_err
);
   localparam int PW = ptr_w(NM);
   localparam int WW = $clog2(TIMEOUT + 1);
   state_t state, state_nx;
   logic [PW-1:0] rr_ptr, g_idx, pick_idx, nxt_ptr;
   logic [NM-1:0] req, pick_oh;
   logic [WW-1:0] wdog;
   logic any, busy, done, abort;
   assign req = bus.m_read | bus.m_write;
   assign busy = state == BUSY;
   // a dropped request releases the grant like a completion
   assign done = busy && (!bus.s_waitrequest || !req[g_idx]);
   assign abort = busy && bus.s_waitrequest && req[g_idx] && wdog == WW'(TIMEOUT - 1);
   assign nxt_ptr = g_idx == PW'(NM - 1) ? '0 : g_idx + PW'(1);
   rr_priority_pick #(.NM(NM), .PW(PW)) u_pick (
      .req(req),
      .ptr(rr_ptr),
      .grant(pick_oh),
      .idx(pick_idx),
      .any(any)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         grant <= '0;
         g_idx <= '0;
         rr_ptr <= '0;
         wdog <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nx;
         timeout_err <= abort;
         if (!busy) begin
            grant <= pick_oh;
            g_idx <= pick_idx;
            wdog <= '0;
         end else if (done || abort) begin
            grant <= '0;
            rr_ptr <= nxt_ptr;
         end else if (wdog != WW'(TIMEOUT)) begin
            wdog <= wdog + WW'(1);
         end
      end
   end
   always_comb state_nx = !busy ? (any ? BUSY : IDLE) : (done || abort ? IDLE : BUSY);
   always_comb begin
      bus.s_address = busy ? bus.m_address[g_idx*AW +: AW] : '0;
      bus.s_writedata = busy ? bus.m_writedata[g_idx*DW +: DW] : '0;
      bus.s_byteenable = busy ? bus.m_byteenable[g_idx*N +: N] : '0;
      bus.s_write = busy && bus.m_write[g_idx];
      bus.s_read = busy && bus.m_read[g_idx] && !bus.m_write[g_idx];
      bus.s_chipselect = busy;
      bus.m_waitrequest = ~grant | {NM{bus.s_waitrequest}};
      bus.m_readdata = bus.s_readdata;
   end
endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// tb_avalon_mm_arbiter: scenario tasks against a wait-state memory model and scoreboard queues
module tb_avalon_mm_arbiter;
   localparam int NM = 2, DW = 32, AW = 32, N = 4, TO = 8;
   logic clk = 0, reset = 0;
   logic [NM-1:0] grant;
   logic timeout_err;
   int vectors = 0, miscompares = 0;
   logic [31:0] mem [64];
   int wait_n = 0, wcnt = 0;
   bit stall_all = 0;
   logic [31:0] exp_rd [$];
   logic [NM-1:0] exp_gnt [$];
   logic exp_wq [$];

   avalon_mm_arbiter_if #(.NM(NM), .DW(DW), .AW(AW), .N(N)) bus();
   avalon_mm_arbiter #(.NM(NM), .DW(DW), .AW(AW), .N(N), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .bus(bus), .grant(grant), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;
   assign bus.s_waitrequest = stall_all || (wcnt < wait_n);
   assign bus.s_readdata = mem[bus.s_address[5:0]];
   always @(posedge clk) begin
      if (bus.s_chipselect && bus.s_write && !bus.s_waitrequest)
         for (int b = 0; b < 4; b++)
            if (bus.s_byteenable[b]) mem[bus.s_address[5:0]][b*8 +: 8] <= bus.s_writedata[b*8 +: 8];
      wcnt <= bus.s_chipselect ? wcnt + 1 : 0;
   end

   task automatic drive(input int i, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      bus.m_read[i] = rd;
      bus.m_write[i] = wr;
      bus.m_address[i*AW +: AW] = a;
      bus.m_writedata[i*DW +: DW] = d;
      bus.m_byteenable[i*N +: N] = be;
   endtask

   task automatic idle_all;
      bus.m_read = '0;
      bus.m_write = '0;
      bus.m_address = '0;
      bus.m_writedata = '0;
      bus.m_byteenable = '0;
   endtask

   task automatic do_reset;
      reset = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1;
   endtask

   task automatic xfer(input int i, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       output logic [31:0] rdata, output bit ok);
      ok = 0;
      rdata = '0;
      drive(i, rd, wr, a, d, be);
      for (int c = 0; c < 40 && !ok; c++) begin
         @(negedge clk);
         if (grant[i] && !bus.m_waitrequest[i]) begin
            ok = 1;
            rdata = bus.m_readdata;
         end
      end
      @(posedge clk);
      #1;
      bus.m_read[i] = 0;
      bus.m_write[i] = 0;
   endtask

   task automatic test_reset;
      idle_all();
      reset = 0;
      @(negedge clk);
      vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL reset grant: got %b want 00", grant); end
      vectors++; if (bus.s_chipselect !== 1'b0) begin miscompares++; $display("FAIL reset chipselect: got %b want 0", bus.s_chipselect); end
      vectors++; if ({bus.s_read, bus.s_write} !== 2'b00) begin miscompares++; $display("FAIL reset rd/wr: got %b want 00", {bus.s_read, bus.s_write}); end
      vectors++; if (bus.s_address !== 32'h0 || bus.s_writedata !== 32'h0 || bus.s_byteenable !== 4'h0) begin miscompares++; $display("FAIL reset slave bus: got %h/%h/%h want 0", bus.s_address, bus.s_writedata, bus.s_byteenable); end
      vectors++; if (bus.m_waitrequest !== 2'b11) begin miscompares++; $display("FAIL reset waitrequest: got %b want 11", bus.m_waitrequest); end
      vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL reset timeout_err: got %b want 0", timeout_err); end
      @(posedge clk);
      #1 reset = 1;
   endtask

   task automatic test_single_write;
      logic [31:0] rdata;
      bit ok;
      wait_n = 2;
      exp_wq = '{1'b1, 1'b1, 1'b1, 1'b0};
      drive(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
      for (int c = 0; c < 4; c++) begin
         logic e;
         @(negedge clk);
         e = exp_wq.pop_front();
         vectors++; if (bus.m_waitrequest[0] !== e) begin miscompares++; $display("FAIL wr waitreq cyc%0d: got %b want %b", c, bus.m_waitrequest[0], e); end
         if (c >= 1) begin
            vectors++; if ({bus.s_write, bus.s_address, bus.s_writedata} !== {1'b1, 32'h10, 32'hDEADBEEF}) begin miscompares++; $display("FAIL wr slave cyc%0d: got %b %h %h want 1 10 deadbeef", c, bus.s_write, bus.s_address, bus.s_writedata); end
         end
      end
      @(posedge clk);
      #1 bus.m_write[0] = 0;
      @(negedge clk);
      vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL wr gap grant: got %b want 00", grant); end
      exp_rd.push_back(32'hDEADBEEF);
      xfer(0, 1, 0, 32'h10, 0, 4'hF, rdata, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rdback timeout: got no completion want completion"); end
      vectors++; if (rdata !== exp_rd[0]) begin miscompares++; $display("FAIL rdback data: got %h want %h", rdata, exp_rd[0]); end
      void'(exp_rd.pop_front());
   endtask

   task automatic test_contention;
      logic [NM-1:0] prev_g = '0;
      bit prev_done = 0;
      do_reset();
      wait_n = 1;
      exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
      drive(0, 1, 0, 32'h10, 0, 4'hF);
      drive(1, 1, 0, 32'h05, 0, 4'hF);
      for (int c = 0; c < 60 && exp_gnt.size() != 0; c++) begin
         @(negedge clk);
         if (prev_done) begin
            vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL rr gap: got %b want 00", grant); end
         end
         if (grant == 2'b01) begin
            vectors++; if (bus.m_waitrequest[1] !== 1'b1) begin miscompares++; $display("FAIL rr m1 stall: got %b want 1", bus.m_waitrequest[1]); end
         end
         if (grant != 0 && prev_g == 0) begin
            logic [NM-1:0] e = exp_gnt.pop_front();
            vectors++; if (grant !== e) begin miscompares++; $display("FAIL rr order: got %b want %b", grant, e); end
         end
         prev_done = grant != 0 && !bus.s_waitrequest;
         prev_g = grant;
      end
      vectors++; if (exp_gnt.size() != 0) begin miscompares++; $display("FAIL rr timeout: got %0d grants left want 0", exp_gnt.size()); end
      exp_gnt.delete();
      @(posedge clk);
      #1 idle_all();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_byteenable;
      logic [31:0] rdata;
      bit ok;
      int seen = 0;
      wait_n = 1;
      xfer(1, 0, 1, 32'h5, 32'hFFFFFFFF, 4'hF, rdata, ok);
      drive(1, 0, 1, 32'h5, 32'h11223344, 4'b0101);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (grant == 2'b10) begin
            seen++;
            vectors++; if ({bus.s_byteenable, bus.s_writedata, bus.s_address} !== {4'b0101, 32'h11223344, 32'h5}) begin miscompares++; $display("FAIL be pass: got %b %h %h want 0101 11223344 5", bus.s_byteenable, bus.s_writedata, bus.s_address); end
            if (!bus.m_waitrequest[1]) break;
         end
      end
      @(posedge clk);
      #1 bus.m_write[1] = 0;
      vectors++; if (seen == 0) begin miscompares++; $display("FAIL be grant: got no m1 grant want grant"); end
      exp_rd.push_back(32'hFF22FF44);
      xfer(1, 1, 0, 32'h5, 0, 4'hF, rdata, ok);
      vectors++; if (rdata !== exp_rd[0] || !ok) begin miscompares++; $display("FAIL be rdback: got %h want %h", rdata, exp_rd[0]); end
      void'(exp_rd.pop_front());
   endtask

   task automatic test_watchdog;
      int busy0 = 0, te = 0;
      bit got1 = 0;
      do_reset();
      wait_n = 0;
      stall_all = 1;
      drive(0, 1, 0, 32'h0, 0, 4'hF);
      drive(1, 1, 0, 32'h5, 0, 4'hF);
      for (int c = 0; c < 40 && !got1; c++) begin
         @(negedge clk);
         if (grant == 2'b01) busy0++;
         if (timeout_err) begin
            te++;
            vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL wd idle on err: got %b want 00", grant); end
         end
         if (grant == 2'b10) got1 = 1;
      end
      vectors++; if (busy0 != TO) begin miscompares++; $display("FAIL wd busy cycles: got %0d want %0d", busy0, TO); end
      vectors++; if (te != 1) begin miscompares++; $display("FAIL wd err pulses: got %0d want 1", te); end
      vectors++; if (!got1) begin miscompares++; $display("FAIL wd regrant: got no m1 grant want 10"); end
      stall_all = 0;
      bus.m_read[0] = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL wd spurious err cyc%0d: got 1 want 0", c); end
      end
      @(posedge clk);
      #1 idle_all();
   endtask

   task automatic test_reset_mid;
      logic [31:0] rdata;
      bit ok;
      bit granted = 0;
      wait_n = 1;
      xfer(0, 1, 0, 32'h10, 0, 4'hF, rdata, ok);
      stall_all = 1;
      drive(0, 0, 1, 32'h30, 32'h12345678, 4'hF);
      for (int c = 0; c < 5 && !granted; c++) begin
         @(negedge clk);
         granted = grant == 2'b01;
      end
      vectors++; if (!granted) begin miscompares++; $display("FAIL rstmid grant: got %b want 01", grant); end
      #2 reset = 0;
      #1;
      vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL rstmid async grant: got %b want 00", grant); end
      vectors++; if (bus.s_chipselect !== 1'b0) begin miscompares++; $display("FAIL rstmid chipselect: got %b want 0", bus.s_chipselect); end
      vectors++; if (bus.m_waitrequest !== 2'b11) begin miscompares++; $display("FAIL rstmid waitreq: got %b want 11", bus.m_waitrequest); end
      stall_all = 0;
      drive(1, 1, 0, 32'h5, 0, 4'hF);
      exp_gnt.push_back(2'b01);
      @(posedge clk);
      #1 reset = 1;
      for (int c = 0; c < 5 && grant == 0; c++) @(negedge clk);
      vectors++; if (grant !== exp_gnt[0]) begin miscompares++; $display("FAIL rstmid first grant: got %b want %b", grant, exp_gnt[0]); end
      void'(exp_gnt.pop_front());
      @(posedge clk);
      #1 idle_all();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_conflict;
      logic [31:0] rdata;
      bit ok;
      int seen = 0;
      wait_n = 1;
      drive(0, 1, 1, 32'h20, 32'hCAFEF00D, 4'hF);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (grant == 2'b01) begin
            seen++;
            vectors++; if ({bus.s_write, bus.s_read} !== 2'b10) begin miscompares++; $display("FAIL conflict wr/rd: got %b want 10", {bus.s_write, bus.s_read}); end
            if (!bus.m_waitrequest[0]) break;
         end
      end
      @(posedge clk);
      #1 idle_all();
      vectors++; if (seen == 0) begin miscompares++; $display("FAIL conflict grant: got none want 01"); end
      exp_rd.push_back(32'hCAFEF00D);
      xfer(0, 1, 0, 32'h20, 0, 4'hF, rdata, ok);
      vectors++; if (rdata !== exp_rd[0] || !ok) begin miscompares++; $display("FAIL conflict rdback: got %h want %h", rdata, exp_rd[0]); end
      void'(exp_rd.pop_front());
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_contention();
      test_byteenable();
      test_watchdog();
      test_reset_mid();
      test_conflict();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/avalon_mm_arbiter.md
Name: avalon_mm_arbiter

Overview:
- Round-robin arbiter that shares one Avalon-MM slave (the memory slave, DW=32, AW=32) among NM requesting masters.
- Grants one transfer at a time and muxes the granted master's command onto the slave port.
- Routes slave waitrequest back to the granted master only and broadcasts readdata.
- Bounds each transfer with a watchdog counter that aborts a transfer stalled by the slave.

Parameters:
NM, 2, number of masters (2..8)
DW, 32, data width
N, DW/8, byte lanes
AW, 32, address width
TIMEOUT, 64, max cycles a granted transfer may wait before abort (>=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
m_address  in  NM*AW  master i address at [i*AW +: AW]
m_read  in  NM  per-master read request
m_write  in  NM  per-master write request
m_writedata  in  NM*DW  master i write data at [i*DW +: DW]
m_byteenable  in  NM*N  master i byte enables at [i*N +: N]
m_waitrequest  out  NM  per-master stall
m_readdata  out  DW  slave readdata, broadcast to all masters
s_address  out  AW  to slave
s_read  out  1  to slave
s_write  out  1  to slave
s_chipselect  out  1  to slave
s_writedata  out  DW  to slave
s_byteenable  out  N  to slave
s_waitrequest  in  1  from slave
s_readdata  in  DW  from slave
grant  out  NM  one-hot current owner; 0 when idle
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: grant=0, s_read=s_write=s_chipselect=0, s_address=0, s_writedata=0, s_byteenable=0, m_waitrequest all 1, timeout_err=0.
  - Internal: rr_ptr=0, wdog=0, state=IDLE.
- Requests: req[i] = m_read[i] | m_write[i].
- Read/write conflict: if a master asserts both, write wins; s_read = rd & ~wr.
- FSM states: IDLE, BUSY.
- IDLE: if any req, choose the first i with req[i], searching from rr_ptr upward modulo NM. At the edge, grant<=onehot(i), go to BUSY, wdog<=0. With no req, stay in IDLE.
- BUSY: slave outputs are a combinational mux of the granted master's signals, and s_chipselect=1.
  - m_waitrequest[g] = s_waitrequest. All other m_waitrequest bits = 1.
  - In IDLE, all m_waitrequest bits = 1.
- Completion: a BUSY cycle with s_waitrequest=0 and the granted req=1. At that edge: grant<=0, rr_ptr<=(g+1) mod NM, go to IDLE.
  - Exactly one transfer per grant.
  - There is one IDLE gap cycle between consecutive grants.
- Latency: a request first seen in cycle 0 reaches the slave in cycle 1. Minimum 2 cycles request-to-completion.
- Read data: m_readdata = s_readdata at all times. It is valid to the granted master in its completion cycle.
- Watchdog: wdog increments in every BUSY cycle with s_waitrequest=1, saturating at TIMEOUT.
  - When wdog reaches TIMEOUT-1 with s_waitrequest still 1: abort at that edge. grant<=0, rr_ptr<=(g+1) mod NM, timeout_err=1 for the next cycle, go to IDLE.
  - The aborted master sees m_waitrequest=1 throughout and re-arbitrates normally.
- Master drops req while BUSY (protocol violation): release at that edge. Treat as completion, with no error and the pointer advanced.
- Simultaneous completion and watchdog expiry: completion wins, timeout_err=0.
- NM=1: the pointer stays 0, and the 1-cycle idle gap still applies.
- Reset asserted mid-BUSY: immediate release. s_chipselect drops asynchronously and no partial state is retained.

Decomposition:
- Shared package avalon_mm_pkg: DW, AW, N defaults; FSM state encoding (IDLE=1'b0, BUSY=1'b1); TIMEOUT default.
- One sub-module, rr_priority_pick: combinational pick of the first set bit of req rotated by rr_ptr. Outputs a one-hot grant and an index.
- The mux and watchdog stay in the top level.

Test Plan:
- Single master write (NM=2, slave waitrequest 2 cycles): m0 write addr=0x10, data=0xDEADBEEF, be=4'hF. The slave sees s_write=1 with that addr/data from cycle 1; m_waitrequest[0] low in cycle 3; readback of addr 0x10 returns 0xDEADBEEF.
- Contention: m0 and m1 both read continuously, with rr_ptr=0 after reset. Grant order is m0, m1, m0, m1, with one IDLE cycle between grants. m_waitrequest[1]=1 throughout every m0 grant.
- Byteenable passthrough: m1 writes 0x11223344 with be=4'b0101 to addr 5. s_byteenable=4'b0101 and s_writedata=0x11223344 while m1 is granted.
- Watchdog (TIMEOUT=8): the slave holds waitrequest=1 indefinitely.
  - Abort after 8 BUSY cycles, and timeout_err pulses for exactly 1 cycle.
  - grant returns to 0, then the other master is granted.
- Reset mid-transfer: drive reset=0 during m0 BUSY. Asynchronously grant=0, s_chipselect=0, all m_waitrequest=1. After release, the first grant goes to m0 (rr_ptr=0).
- Read+write conflict: m0 asserts read=1 and write=1 together. The slave sees s_write=1 and s_read=0.
